// File: rtl/si_cfg_scheduler.sv
// Sensor clock-config scheduler: qualifies a stable cfg id over several frames,
// then walks its table-ROM sequence through the I2C write engine with per-step retry.
module si_cfg_scheduler #(
  parameter int STABLE_FRAMES = 4,
  parameter int MAX_STEPS     = 8,
  parameter int MAX_RETRY     = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [4:0]  i_cfg_id,
  input  logic        i_frame_change,
  input  logic        i_force,
  output logic [7:0]  o_tbl_idx,
  input  logic [15:0] i_tbl_data,
  output logic        o_wr_req,
  output logic [7:0]  o_wr_addr,
  output logic [7:0]  o_wr_data,
  input  logic        i_wr_done,
  input  logic        i_wr_nack,
  output logic        o_busy,
  output logic [4:0]  o_applied_id,
  output logic        o_applied_valid,
  output logic        o_error
);

  localparam int CW = $clog2(STABLE_FRAMES + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int SW = 3;

  typedef enum logic [3:0] {
    S_IDLE, S_QUALIFY, S_FETCH, S_LATCH, S_ISSUE, S_WAIT, S_GAP, S_DONE, S_ERROR
  } state_e;

  state_e        state_q, state_d;
  logic [4:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] step_q, step_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [RW:0]   retry_inc;

  logic          wr_req_q, wr_req_d;
  logic [7:0]    wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    tbl_idx_q, tbl_idx_d;
  logic [4:0]    applied_id_q, applied_id_d;
  logic          applied_vld_q, applied_vld_d;
  logic          error_q, error_d;
  logic          busy_q, busy_d;

  assign retry_inc = {1'b0, retry_q} + 1'b1;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      cand_q        <= '0;
      cnt_q         <= '0;
      step_q        <= '0;
      retry_q       <= '0;
      wr_req_q      <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      tbl_idx_q     <= '0;
      applied_id_q  <= '0;
      applied_vld_q <= 1'b0;
      error_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      step_q        <= step_d;
      retry_q       <= retry_d;
      wr_req_q      <= wr_req_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      tbl_idx_q     <= tbl_idx_d;
      applied_id_q  <= applied_id_d;
      applied_vld_q <= applied_vld_d;
      error_q       <= error_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state and sequencing counters
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    retry_d = retry_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_force) begin
          state_d = S_FETCH;
          cand_d  = i_cfg_id;
          step_d  = '0;
          retry_d = '0;
        end else if (!applied_vld_q || i_cfg_id != applied_id_q) begin
          state_d = S_QUALIFY;
          cand_d  = i_cfg_id;
          cnt_d   = '0;
        end
      end
      S_QUALIFY: begin
        if (i_force) begin
          state_d = S_FETCH;
          cand_d  = i_cfg_id;
          step_d  = '0;
          retry_d = '0;
        end else if (applied_vld_q && i_cfg_id == applied_id_q) begin
          state_d = S_IDLE;
        end else if (i_cfg_id != cand_q) begin
          // id moved: restart the stability window, this frame is not counted
          cand_d = i_cfg_id;
          cnt_d  = '0;
        end else if (i_frame_change) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(STABLE_FRAMES - 1)) begin
            state_d = S_FETCH;
            step_d  = '0;
            retry_d = '0;
          end
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: state_d = (i_tbl_data[15:8] == 8'hFF) ? S_DONE : S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (i_wr_done) begin
          if (!i_wr_nack) begin
            if (step_q == SW'(MAX_STEPS - 1)) begin
              state_d = S_DONE;
            end else begin
              state_d = S_FETCH;
              step_d  = step_q + 1'b1;
              retry_d = '0;
            end
          end else if (retry_inc < (RW+1)'(MAX_RETRY)) begin
            state_d = S_GAP;
            retry_d = retry_inc[RW-1:0];
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      S_GAP:   state_d = S_ISSUE;
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs derived from the upcoming state
  always_comb begin
    wr_req_d      = (state_d == S_ISSUE) || (state_d == S_WAIT);
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    tbl_idx_d     = tbl_idx_q;
    applied_id_d  = applied_id_q;
    applied_vld_d = applied_vld_q;
    error_d       = error_q;
    busy_d        = (state_d != S_IDLE);
    if (state_q == S_LATCH) begin
      wr_addr_d = i_tbl_data[15:8];
      wr_data_d = i_tbl_data[7:0];
    end
    if (state_d == S_FETCH) tbl_idx_d = {cand_d, step_d};
    if (state_q == S_DONE || state_q == S_ERROR) begin
      // an aborted id is still recorded so it is not retried until the id changes
      applied_id_d  = cand_q;
      applied_vld_d = 1'b1;
      error_d       = (state_q == S_ERROR);
    end
  end

  assign o_wr_req        = wr_req_q;
  assign o_wr_addr       = wr_addr_q;
  assign o_wr_data       = wr_data_q;
  assign o_tbl_idx       = tbl_idx_q;
  assign o_applied_id    = applied_id_q;
  assign o_applied_valid = applied_vld_q;
  assign o_error         = error_q;
  assign o_busy          = busy_q;

endmodule
